// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller and its
// forwarding-select sub-block.
package hazard_pkg;
  localparam int REG_ADDR_W = 5;

  localparam logic [1:0] FWD_REGFILE = 2'b00;
  localparam logic [1:0] FWD_WB      = 2'b01;
  localparam logic [1:0] FWD_MEM     = 2'b10;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    FLUSH      = 2'd2
  } hazard_state_t;
endpackage

// File: rtl/forwarding_select.sv
// Operand bypass select for one execute-stage source register.
// MEM-stage results win over WB-stage results; x0 is never bypassed.
module forwarding_select
  import hazard_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] exRs,
  input  logic [REG_ADDR_W-1:0] memRd,
  input  logic                  memRegisterWriteEnable,
  input  logic [REG_ADDR_W-1:0] wbRd,
  input  logic                  wbRegisterWriteEnable,
  output logic [1:0]            sel
);
  always_comb begin
    sel = FWD_REGFILE;
    if (memRegisterWriteEnable && memRd != '0 && memRd == exRs)
      sel = FWD_MEM;
    else if (wbRegisterWriteEnable && wbRd != '0 && wbRd == exRs)
      sel = FWD_WB;
  end
endmodule

// File: rtl/pipeline_hazard_controller.sv
// Load-use stall / branch flush sequencer and ALU operand forwarding.
// Optional HAZARD_PERF_COUNTERS_EN adds saturating stall/flush counters.
module pipeline_hazard_controller
  import hazard_pkg::*;
#(
  parameter int LOAD_USE_STALLS = 1,
  parameter int FLUSH_EXTRA     = 0
) (
  input  logic                  clock,
  input  logic                  resetN,
  input  logic [REG_ADDR_W-1:0] idRs1,
  input  logic [REG_ADDR_W-1:0] idRs2,
  input  logic                  idUsesRs1,
  input  logic                  idUsesRs2,
  input  logic [REG_ADDR_W-1:0] exRd,
  input  logic [REG_ADDR_W-1:0] exRs1,
  input  logic [REG_ADDR_W-1:0] exRs2,
  input  logic                  exMemoryReadEnable,
  input  logic                  exBranchTaken,
  input  logic [REG_ADDR_W-1:0] memRd,
  input  logic                  memRegisterWriteEnable,
  input  logic [REG_ADDR_W-1:0] wbRd,
  input  logic                  wbRegisterWriteEnable,
  output logic                  pcStall,
  output logic                  ifIdStall,
  output logic                  ifIdFlush,
  output logic                  idExBubble,
  output logic [1:0]            forwardA,
  output logic [1:0]            forwardB,
  output logic [1:0]            hazardState,
  output logic [31:0]           stallCycleCount,
  output logic [31:0]           flushCount
);
  if (LOAD_USE_STALLS < 1 || LOAD_USE_STALLS > 7) begin : g_bad_lus
    $error("LOAD_USE_STALLS must be in 1..7");
  end
  if (FLUSH_EXTRA < 0 || FLUSH_EXTRA > 7) begin : g_bad_fe
    $error("FLUSH_EXTRA must be in 0..7");
  end

  // First stall/flush cycle is issued from RUN, so the counter covers the rest.
  localparam logic [2:0] LU_RELOAD = 3'((LOAD_USE_STALLS > 1) ? LOAD_USE_STALLS - 2 : 0);
  localparam logic [2:0] FE_RELOAD = 3'((FLUSH_EXTRA > 0) ? FLUSH_EXTRA - 1 : 0);

  hazard_state_t state;
  logic [2:0]    cnt;
  logic          loadUse;
  logic [1:0]    selA, selB;

  assign loadUse = exMemoryReadEnable && exRd != '0 &&
                   ((idUsesRs1 && idRs1 == exRd) || (idUsesRs2 && idRs2 == exRd));

  always_comb begin
    pcStall    = 1'b0;
    ifIdStall  = 1'b0;
    ifIdFlush  = 1'b0;
    idExBubble = 1'b0;
    if (resetN) begin
      case (state)
        RUN: begin
          if (exBranchTaken) begin
            ifIdFlush  = 1'b1;
            idExBubble = 1'b1;
          end else if (loadUse) begin
            pcStall    = 1'b1;
            ifIdStall  = 1'b1;
            idExBubble = 1'b1;
          end
        end
        LOAD_STALL: begin
          pcStall    = 1'b1;
          ifIdStall  = 1'b1;
          idExBubble = 1'b1;
        end
        FLUSH: begin
          ifIdFlush  = 1'b1;
          idExBubble = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      case (state)
        RUN: begin
          if (exBranchTaken) begin
            if (FLUSH_EXTRA > 0) begin
              state <= FLUSH;
              cnt   <= FE_RELOAD;
            end
          end else if (loadUse && LOAD_USE_STALLS > 1) begin
            state <= LOAD_STALL;
            cnt   <= LU_RELOAD;
          end
        end
        LOAD_STALL, FLUSH: begin
          if (cnt == '0) state <= RUN;
          else           cnt   <= cnt - 3'd1;
        end
        default: begin
          state <= RUN;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign hazardState = state;

  forwarding_select u_fwd_a (
    .exRs                  (exRs1),
    .memRd                 (memRd),
    .memRegisterWriteEnable(memRegisterWriteEnable),
    .wbRd                  (wbRd),
    .wbRegisterWriteEnable (wbRegisterWriteEnable),
    .sel                   (selA)
  );

  forwarding_select u_fwd_b (
    .exRs                  (exRs2),
    .memRd                 (memRd),
    .memRegisterWriteEnable(memRegisterWriteEnable),
    .wbRd                  (wbRd),
    .wbRegisterWriteEnable (wbRegisterWriteEnable),
    .sel                   (selB)
  );

  assign forwardA = resetN ? selA : FWD_REGFILE;
  assign forwardB = resetN ? selB : FWD_REGFILE;

`ifdef HAZARD_PERF_COUNTERS_EN
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      stallCycleCount <= '0;
      flushCount      <= '0;
    end else begin
      if (pcStall && stallCycleCount != '1)
        stallCycleCount <= stallCycleCount + 32'd1;
      if (state == RUN && exBranchTaken && flushCount != '1)
        flushCount <= flushCount + 32'd1;
    end
  end
`else
  assign stallCycleCount = '0;
  assign flushCount      = '0;
`endif
endmodule
